// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O controller: LED/HEX registers, synchronised switches,
// debounced keys with sticky press capture, periodic timer and a maskable interrupt.
module mmio_io_ctrl #(
    parameter int N_LED      = 10,
    parameter int N_SW       = 10,
    parameter int N_KEY      = 4,
    parameter int N_HEX      = 6,
    parameter int DEB_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 memwrite,
    input  logic [31:0]          addr,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [N_KEY-1:0]     key_n,
    input  logic [N_SW-1:0]      sw,
    output logic [N_LED-1:0]     ledr,
    output logic [4*N_HEX-1:0]   hex_digits,
    output logic                 irq
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [N_LED-1:0]   led_r;
    logic [4*N_HEX-1:0] hex_r;
    logic [N_KEY-1:0]   key_sync1_r, key_sync2_r;
    logic [N_SW-1:0]    sw_sync1_r, sw_sync2_r;
    logic [N_KEY-1:0]   kst_r, kst_nxt_s;
    logic [CW-1:0]      deb_r     [N_KEY];
    logic [CW-1:0]      deb_nxt_s [N_KEY];
    logic [N_KEY-1:0]   key_edge_r, key_edge_nxt_s;
    logic [31:0]        tmr_cmp_r, tmr_cnt_r, tmr_cnt_nxt_s;
    logic               tmr_flag_r, tmr_flag_nxt_s, tmr_wrap_s;
    logic [N_KEY-1:0]   irq_key_en_r;
    logic               irq_tmr_en_r;
    logic               irq_r, irq_nxt_s;
    logic               wr_s;
    logic [3:0]         off_s;
    logic [31:0]        rd_s;
    logic               unused_s;

    assign wr_s     = sel & memwrite;
    assign off_s    = addr[5:2];
    assign unused_s = ^{addr[31:6], addr[1:0], writedata};

    // Per-key debounce and sticky press capture; a new press beats a same-cycle clear.
    always_comb begin
        kst_nxt_s = kst_r;
        for (int i = 0; i < N_KEY; i++) begin
            deb_nxt_s[i] = deb_r[i];
            if (key_sync2_r[i] != kst_r[i]) begin
                if (deb_r[i] == DEB_LAST) begin
                    kst_nxt_s[i] = key_sync2_r[i];
                    deb_nxt_s[i] = {CW{1'b0}};
                end else begin
                    deb_nxt_s[i] = deb_r[i] + CW'(1);
                end
            end else begin
                deb_nxt_s[i] = {CW{1'b0}};
            end
        end
        if (wr_s && (off_s == 4'd4)) begin
            key_edge_nxt_s = key_edge_r & ~writedata[N_KEY-1:0];
        end else begin
            key_edge_nxt_s = key_edge_r;
        end
        key_edge_nxt_s = key_edge_nxt_s | (kst_nxt_s & ~kst_r);
    end

    // Timer: writes to compare or count restart from zero; a wrap beats a same-cycle flag clear.
    always_comb begin
        tmr_cnt_nxt_s = tmr_cnt_r;
        tmr_wrap_s    = 1'b0;
        if (wr_s && ((off_s == 4'd5) || (off_s == 4'd6))) begin
            tmr_cnt_nxt_s = 32'd0;
        end else if (tmr_cmp_r == 32'd0) begin
            tmr_cnt_nxt_s = 32'd0;
        end else if (tmr_cnt_r == (tmr_cmp_r - 32'd1)) begin
            tmr_cnt_nxt_s = 32'd0;
            tmr_wrap_s    = 1'b1;
        end else begin
            tmr_cnt_nxt_s = tmr_cnt_r + 32'd1;
        end
        if (wr_s && (off_s == 4'd7) && writedata[0]) begin
            tmr_flag_nxt_s = tmr_wrap_s;
        end else begin
            tmr_flag_nxt_s = tmr_flag_r | tmr_wrap_s;
        end
        irq_nxt_s = (|(key_edge_r & irq_key_en_r)) | (tmr_flag_r & irq_tmr_en_r);
    end

    // Synchronisers, debounce state, timer and interrupt registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_sync1_r <= {N_KEY{1'b0}};
            key_sync2_r <= {N_KEY{1'b0}};
            sw_sync1_r  <= {N_SW{1'b0}};
            sw_sync2_r  <= {N_SW{1'b0}};
            kst_r       <= {N_KEY{1'b0}};
            for (int i = 0; i < N_KEY; i++) deb_r[i] <= {CW{1'b0}};
            key_edge_r  <= {N_KEY{1'b0}};
            tmr_cnt_r   <= 32'd0;
            tmr_flag_r  <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            key_sync1_r <= ~key_n;
            key_sync2_r <= key_sync1_r;
            sw_sync1_r  <= sw;
            sw_sync2_r  <= sw_sync1_r;
            kst_r       <= kst_nxt_s;
            for (int i = 0; i < N_KEY; i++) deb_r[i] <= deb_nxt_s[i];
            key_edge_r  <= key_edge_nxt_s;
            tmr_cnt_r   <= tmr_cnt_nxt_s;
            tmr_flag_r  <= tmr_flag_nxt_s;
            irq_r       <= irq_nxt_s;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r        <= {N_LED{1'b0}};
            hex_r        <= {(4*N_HEX){1'b0}};
            tmr_cmp_r    <= 32'd0;
            irq_key_en_r <= {N_KEY{1'b0}};
            irq_tmr_en_r <= 1'b0;
        end else if (wr_s) begin
            case (off_s)
                4'd0: led_r <= writedata[N_LED-1:0];
                4'd1: hex_r <= writedata[4*N_HEX-1:0];
                4'd5: tmr_cmp_r <= writedata;
                4'd8: begin
                    irq_key_en_r <= writedata[N_KEY-1:0];
                    irq_tmr_en_r <= writedata[31];
                end
                default: led_r <= led_r;
            endcase
        end else begin
            led_r <= led_r;
        end
    end

    // Combinational read mux over registered state.
    always_comb begin
        rd_s = 32'd0;
        if (sel) begin
            case (off_s)
                4'd0: rd_s[N_LED-1:0]   = led_r;
                4'd1: rd_s[4*N_HEX-1:0] = hex_r;
                4'd2: rd_s[N_KEY-1:0]   = kst_r;
                4'd3: rd_s[N_SW-1:0]    = sw_sync2_r;
                4'd4: rd_s[N_KEY-1:0]   = key_edge_r;
                4'd5: rd_s              = tmr_cmp_r;
                4'd6: rd_s              = tmr_cnt_r;
                4'd7: rd_s[0]           = tmr_flag_r;
                4'd8: begin
                    rd_s[N_KEY-1:0] = irq_key_en_r;
                    rd_s[31]        = irq_tmr_en_r;
                end
                default: rd_s = 32'd0;
            endcase
        end else begin
            rd_s = 32'd0;
        end
    end

    assign readdata   = rd_s;
    assign ledr       = led_r;
    assign hex_digits = hex_r;
    assign irq        = irq_r;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: randomized stimulus against a cycle-count
// reference model of the register map, debounce and timer behaviour.
module tb_mmio_io_ctrl;

    localparam int DEB = 2;
    localparam logic [31:0] A_LED = 32'h00, A_HEX = 32'h04, A_KEY = 32'h08, A_SW = 32'h0C,
                            A_EDGE = 32'h10, A_CMP = 32'h14, A_CNT = 32'h18, A_STAT = 32'h1C,
                            A_IEN = 32'h20;

    logic        clk = 1'b0;
    logic        reset, sel, memwrite;
    logic [31:0] addr, writedata, readdata;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [23:0] hex_digits;
    logic        irq;
    int          n_vec = 0;
    int          n_err = 0;

    mmio_io_ctrl #(.N_LED(10), .N_SW(10), .N_KEY(4), .N_HEX(6), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .sel(sel), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .key_n(key_n), .sw(sw),
        .ledr(ledr), .hex_digits(hex_digits), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1; memwrite = 1'b1; addr = a; writedata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; memwrite = 1'b0; addr = a;
        #1;
        d = readdata;
        sel = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        key_n = 4'h0; sw = 10'h3FF; sel = 1'b0; memwrite = 1'b0;
        addr = 32'd0; writedata = 32'd0; reset = 1'b0;
        step(3);
        n_vec++; if (ledr !== 10'd0) begin n_err++; $display("FAIL reset_ledr got %h exp 0", ledr); end
        n_vec++; if (hex_digits !== 24'd0) begin n_err++; $display("FAIL reset_hex got %h exp 0", hex_digits); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", irq); end
        rd(A_KEY, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_key got %h exp 0", d); end
        rd(A_SW, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_sw got %h exp 0", d); end
        key_n = 4'hF; sw = 10'd0;
        reset = 1'b1;
        step(4);
    endtask

    task automatic test_led_hex;
        logic [31:0] d, v, h;
        wr(A_LED, 32'h3FF);
        wr(A_HEX, 32'h123456);
        n_vec++; if (ledr !== 10'h3FF) begin n_err++; $display("FAIL led_out got %h exp 3ff", ledr); end
        n_vec++; if (hex_digits !== 24'h123456) begin n_err++; $display("FAIL hex_out got %h exp 123456", hex_digits); end
        rd(A_HEX, d);
        n_vec++; if (d !== 32'h123456) begin n_err++; $display("FAIL hex_rb got %h exp 123456", d); end
        for (int i = 0; i < 6; i++) begin
            v = $urandom; h = $urandom;
            wr(A_LED, v);
            wr(A_HEX, h);
            rd(A_LED, d);
            n_vec++; if (d !== {22'd0, v[9:0]}) begin n_err++; $display("FAIL led_rand got %h exp %h", d, v[9:0]); end
            n_vec++; if (hex_digits !== h[23:0]) begin n_err++; $display("FAIL hex_rand got %h exp %h", hex_digits, h[23:0]); end
        end
        wr(A_LED, 32'h155);
        wr(A_HEX, 32'hABCDEF);
        wr(32'h30, $urandom);
        rd(32'h30, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped_rd got %h exp 0", d); end
        n_vec++; if (ledr !== 10'h155 || hex_digits !== 24'hABCDEF) begin
            n_err++; $display("FAIL unmapped_wr got %h/%h exp 155/abcdef", ledr, hex_digits); end
    endtask

    task automatic test_sw;
        logic [31:0] d;
        logic [9:0]  prev, v;
        prev = 10'd0;
        for (int i = 0; i < 6; i++) begin
            v = 10'($urandom_range(0, 1023));
            sw = v;
            step(1);
            rd(A_SW, d);
            n_vec++; if (d !== {22'd0, prev}) begin n_err++; $display("FAIL sw_lat1 got %h exp %h", d, prev); end
            step(1);
            rd(A_SW, d);
            n_vec++; if (d !== {22'd0, v}) begin n_err++; $display("FAIL sw_lat2 got %h exp %h", d, v); end
            prev = v;
        end
    endtask

    task automatic test_key_debounce;
        logic [31:0] d, exp_e;
        int k, len;
        key_n[1] = 1'b0; step(1); key_n[1] = 1'b1; step(8);
        rd(A_KEY, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL glitch_key got %h exp 0", d); end
        rd(A_EDGE, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL glitch_edge got %h exp 0", d); end
        key_n[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            rd(A_KEY, d);
            n_vec++; if (d !== ((c >= 2 + DEB) ? 32'h2 : 32'h0)) begin
                n_err++; $display("FAIL press_key c=%0d got %h", c, d); end
        end
        rd(A_EDGE, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL press_edge got %h exp 2", d); end
        key_n[1] = 1'b1; step(10);
        rd(A_KEY, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL release_key got %h exp 0", d); end
        rd(A_EDGE, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL release_edge got %h exp 2", d); end
        wr(A_EDGE, 32'h2);
        rd(A_EDGE, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL w1c_edge got %h exp 0", d); end
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 3);
            len = $urandom_range(1, 2 * DEB);
            key_n[k] = 1'b0; step(len); key_n[k] = 1'b1;
            step(2 + 2 * DEB + 2);
            exp_e = (len >= DEB) ? (32'd1 << k) : 32'd0;
            rd(A_EDGE, d);
            n_vec++; if (d !== exp_e) begin n_err++; $display("FAIL rand_edge k=%0d len=%0d got %h exp %h", k, len, d, exp_e); end
            rd(A_KEY, d);
            n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rand_key got %h exp 0", d); end
            wr(A_EDGE, 32'hF);
        end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        int ce, ci;
        wr(A_IEN, 32'h1);
        wr(A_EDGE, 32'hF);
        ce = 0; ci = 0;
        key_n[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            rd(A_EDGE, d);
            if (d[0] && ce == 0) ce = c;
            if (irq && ci == 0) ci = c;
        end
        n_vec++; if (ce !== 2 + DEB) begin n_err++; $display("FAIL edge_cycle got %0d exp %0d", ce, 2 + DEB); end
        n_vec++; if (ci !== 3 + DEB) begin n_err++; $display("FAIL irq_cycle got %0d exp %0d", ci, 3 + DEB); end
        key_n[0] = 1'b1; step(6);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_sticky got %b exp 1", irq); end
        wr(A_EDGE, 32'h1); step(1);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b exp 0", irq); end
        key_n[0] = 1'b0; step(1 + DEB);
        wr(A_EDGE, 32'h1);
        rd(A_EDGE, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL set_wins_edge got %h exp 1", d); end
        key_n[0] = 1'b1; step(6);
        wr(A_EDGE, 32'h1); step(1);
        rd(A_EDGE, d);
        n_vec++; if (d !== 32'd0 || irq !== 1'b0) begin n_err++; $display("FAIL final_clear got %h/%b exp 0/0", d, irq); end
    endtask

    task automatic test_timer;
        logic [31:0] d, c;
        logic [31:0] cmps [4];
        cmps[0] = 32'd5; cmps[1] = 32'd1; cmps[2] = 32'd3; cmps[3] = 32'($urandom_range(2, 9));
        wr(A_IEN, 32'h8000_0000);
        for (int t = 0; t < 4; t++) begin
            c = cmps[t];
            wr(A_CMP, 32'd0);
            wr(A_STAT, 32'd1);
            wr(A_CMP, c);
            for (int j = 1; j <= 3 * int'(c); j++) begin
                step(1);
                rd(A_CNT, d);
                n_vec++; if (d !== 32'(j) % c) begin n_err++; $display("FAIL tmr_cnt cmp=%0d j=%0d got %0d", c, j, d); end
                rd(A_STAT, d);
                n_vec++; if (d !== ((j >= int'(c)) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL tmr_flag cmp=%0d j=%0d got %0d", c, j, d); end
                n_vec++; if (irq !== (j >= int'(c) + 1)) begin n_err++; $display("FAIL tmr_irq cmp=%0d j=%0d got %b", c, j, irq); end
            end
            wr(A_STAT, 32'd1);
            rd(A_STAT, d);
            n_vec++; if (d !== (((3 * c + 1) % c == 0) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL tmr_w1c cmp=%0d got %0d", c, d); end
            wr(A_CNT, $urandom);
            rd(A_CNT, d);
            n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL cnt_wr_clear got %0d exp 0", d); end
            step(1);
            rd(A_CNT, d);
            n_vec++; if (d !== 32'd1 % c) begin n_err++; $display("FAIL cnt_restart got %0d exp %0d", d, 32'd1 % c); end
            wr(A_CMP, 32'd0);
            wr(A_STAT, 32'd1);
            step(2 * int'(c) + 3);
            rd(A_CNT, d);
            n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL tmr_off_cnt got %0d exp 0", d); end
            rd(A_STAT, d);
            n_vec++; if (d !== 32'd0 || irq !== 1'b0) begin n_err++; $display("FAIL tmr_off_flag got %0d/%b exp 0/0", d, irq); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(A_LED, 32'h2AA);
        wr(A_IEN, 32'h8000_0000);
        wr(A_CMP, 32'd7);
        step(3);
        key_n[2] = 1'b0; step(3);
        reset = 1'b0;
        #1;
        n_vec++; if (ledr !== 10'd0 || hex_digits !== 24'd0 || irq !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_out got %h/%h/%b exp 0/0/0", ledr, hex_digits, irq); end
        rd(A_CNT, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL mid_reset_cnt got %0d exp 0", d); end
        step(2);
        key_n[2] = 1'b1;
        reset = 1'b1;
        step(3);
        rd(A_CNT, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL post_reset_cnt got %0d exp 0", d); end
        key_n[2] = 1'b0;
        step(1 + DEB);
        rd(A_KEY, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL post_reset_early got %h exp 0", d); end
        step(1);
        rd(A_KEY, d);
        n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL post_reset_key got %h exp 4", d); end
        key_n[2] = 1'b1;
        step(6);
    endtask

    initial begin
        test_reset();
        test_led_hex();
        test_sw();
        test_key_debounce();
        test_irq();
        test_timer();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
